operand_buf: RTL and testbench

//  Parametrised operand buffer between MBR and the ALU operand input.

---
 rtl/operand_buf.sv | 79 +++++++
 tb/tb_operand_buf.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/operand_buf.sv
// In-order DEPTH-entry operand queue between MBR and ALU; loads visible 1 cycle later, pop frees a slot same cycle.
// ld_ready drops only when full with no pop; a dropped ld sets sticky overflow. `OPBUF_BYPASS_EN adds an empty-queue ld->out path.
module operand_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_pop,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              not_empty;
  logic              full;
  logic              byp_take;
  logic              push;
  logic              pop;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign ld_ready  = !full | out_pop;

`ifdef OPBUF_BYPASS_EN
  logic byp;
  assign byp       = !not_empty & ld;
  assign out_valid = not_empty | byp;
  assign out_data  = byp ? ld_data : mem[rd_ptr];
  // Consumer takes the operand straight off ld_data; nothing is stored.
  assign byp_take  = byp & out_pop;
`else
  assign out_valid = not_empty;
  assign out_data  = mem[rd_ptr];
  assign byp_take  = 1'b0;
`endif

  assign push = ld & ld_ready & !byp_take;
  assign pop  = out_pop & not_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && push) begin
      mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (ld && !ld_ready)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_buf.sv
// Directed scoreboard bench for operand_buf (DATA_W=16, DEPTH=4).
module tb_operand_buf;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ld;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_pop;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb[$];
  int          mcount = 0;
  logic        mov = 1'b0;

  operand_buf #(.DATA_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ld(ld), .ld_data(ld_data),
    .ld_ready(ld_ready), .out_data(out_data), .out_valid(out_valid),
    .out_pop(out_pop), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; model updated from the inputs, never from DUT outputs.
  task automatic cycle(input logic l, input logic [15:0] d, input logic p, input logic f);
    logic rdy, vld, byp, push, popq;
    logic [15:0] exp;
    @(negedge clk);
    ld = l; ld_data = d; out_pop = p; flush = f;
    #1;
    rdy = (mcount != 4) || p;
    byp = 1'b0;
`ifdef OPBUF_BYPASS_EN
    byp = (mcount == 0) && l;
`endif
    vld  = (mcount != 0) || byp;
    popq = p && (mcount != 0);
    push = l && rdy && !(byp && p);
    chk("ld_ready_pre", 32'(ld_ready), 32'(rdy));
    chk("out_valid_pre", 32'(out_valid), 32'(vld));
    if (byp) chk("bypass_data", 32'(out_data), 32'(d));
    if (popq) begin
      exp = sb[0];
      chk("pop_data", 32'(out_data), 32'(exp));
    end
    @(posedge clk);
    #1;
    if (f) begin
      sb.delete();
      mov = 1'b0;
    end else begin
      if (popq) void'(sb.pop_front());
      if (push) sb.push_back(d);
      if (l && !rdy) mov = 1'b1;
    end
    mcount = sb.size();
    ld = 1'b0; out_pop = 1'b0; flush = 1'b0;
    #1;
    chk("count", 32'(count), 32'(mcount));
    chk("overflow", 32'(overflow), 32'(mov));
    chk("out_valid_post", 32'(out_valid), 32'(mcount != 0));
    chk("ld_ready_post", 32'(ld_ready), 32'(mcount != 4));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_data"}, 32'(out_data), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'h1);
    chk({tag, "_overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [15:0] fill_vals[4];
    fill_vals[0] = 16'h1111; fill_vals[1] = 16'h2222;
    fill_vals[2] = 16'h3333; fill_vals[3] = 16'h4444;

    rst_n = 1'b0; flush = 1'b0; ld = 1'b0; ld_data = '0; out_pop = 1'b0;
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_vals[i], 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drained_count", 32'(count), 32'd0);

    // Overflow on full, then simultaneous ld+pop on full
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_vals[i], 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
    chk("full_swap_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Flush with ld/pop asserted: both ignored
    cycle(1'b1, 16'h0101, 1'b0, 1'b0);
    cycle(1'b1, 16'h0202, 1'b0, 1'b0);
    cycle(1'b1, 16'h0303, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);

    // Wrap: alternating push/pop
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end

    // Empty ld + pop: bypassed or stored depending on build
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
`ifdef OPBUF_BYPASS_EN
    chk("empty_ldpop_count", 32'(count), 32'd0);
`else
    chk("empty_ldpop_count", 32'(count), 32'd1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
`endif

    // Async reset mid-fill
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    cycle(1'b1, 16'h8888, 1'b0, 1'b0);
    chk("midfill_count", 32'(count), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    sb.delete(); mcount = 0; mov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
